uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 pBAUD_RATE, 9600, line bit rate in bits/s.
REQ-002 pSYS_CLK_FREQ, 100000000, sys_clk frequency in Hz.
REQ-003 pPARITY_EN, 0, 1 inserts a parity bit between data and stop.
REQ-004 pPARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when pPARITY_EN=0.
REQ-005 sys_clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_data  input  8  byte to send, sampled only on handshake.
REQ-008 tx_valid  input  1  tx_data holds a byte to send.
REQ-009 tx_ready  output  1  block can accept a byte this cycle.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 tx_busy  output  1  frame in progress (any state except IDLE).

Function
REQ-012 CLKS_PER_BIT SHALL equal pSYS_CLK_FREQ/pBAUD_RATE, integer-truncated (10416 at defaults); the baud counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be reachable only when pPARITY_EN=1.
REQ-014 A byte SHALL be accepted only in a cycle where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a shift register on that edge.
REQ-015 tx_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-016 On acceptance the FSM SHALL enter START on the next edge, clear the baud counter, and drive tx=0 from that edge.
REQ-017 Each of START, every data bit, PARITY and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-018 Data SHALL go out LSB first; a 3-bit bit index SHALL advance on each bit-period end and leave DATA after index 7.
REQ-019 The parity bit SHALL be the XOR of the 8 latched bits, inverted when pPARITY_ODD=1.
REQ-020 STOP SHALL drive tx=1; at its end the FSM SHALL return to IDLE, giving 10 bit periods per frame (11 with parity).
REQ-021 If tx_valid stays high at the end of STOP, the next byte SHALL be accepted in the first IDLE cycle, so its start bit begins 1 cycle after the previous stop bit ends.
REQ-022 Changes on tx_data or tx_valid while tx_busy=1 SHALL NOT affect the frame in progress.
REQ-023 tx SHALL NOT glitch: it is driven from a flop loaded by state and shift-register bit only.

Reset
REQ-024 When rst is asserted, asynchronously: state=IDLE, tx=1, tx_busy=0, baud counter=0, bit index=0, shift register=0; tx_ready=1 once rst is released.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with tx high within the same cycle and no partial bits after release.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state enum (uart_tx_state_t) and a function computing CLKS_PER_BIT from the two frequency parameters, shared with the receiver.
REQ-027 The baud counter SHALL be a sub-module uart_tx_baud_gen (inputs sys_clk, rst, clear; output bit_done pulsing 1 cycle every CLKS_PER_BIT cycles).

Verification
REQ-028 Defaults, send 0x59 -> tx reads 0,1,0,0,1,1,0,1,0,1, each level held 10416 cycles, then idles high.
REQ-029 Loopback into the existing UART receiver (same parameters), send 0x59 -> receiver data_out=8'b0101_1001.
REQ-030 tx_valid held high with 0x00 then 0xFF -> two frames with 1-cycle gap between stop end and second start; tx_ready high exactly 1 cycle between them.
REQ-031 pPARITY_EN=1: 0x59 gives even parity bit 0; with pPARITY_ODD=1 the bit is 1 -> 11-bit frame, stop high.
REQ-032 Assert rst at cycle 30000 of a 0x00 frame -> tx=1 in that same cycle, tx_busy=0; after release no falling edge until the next handshake.
REQ-033 Change tx_data from 0xA5 to 0x3C mid-frame -> the transmitted bits are all 0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-period arithmetic,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Integer-truncated number of sys_clk cycles per line bit.
  function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: bit_done pulses on the last cycle of every CLKS_PER_BIT-cycle
// period; clear holds the count at zero so a period starts cleanly after it drops.
module uart_tx_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign bit_done = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 (optionally 8E1/8O1) framing, LSB first, with a
// valid/ready byte handshake and a registered, glitch-free serial output.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (tx=0)
// DATA   | eight data bits, LSB first
// PARITY | parity bit (only with pPARITY_EN=1)
// STOP   | stop bit (tx=1), then back to IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned pBAUD_RATE    = 9600,
  parameter int unsigned pSYS_CLK_FREQ = 100000000,
  parameter bit          pPARITY_EN    = 1'b0,
  parameter bit          pPARITY_ODD   = 1'b0
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(pSYS_CLK_FREQ, pBAUD_RATE);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0] state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bit_idx;
  logic       bit_done;
  logic       accept;
  logic       tx_q, tx_nxt;

  assign accept   = (state == S_IDLE) && tx_valid;
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);
  assign tx       = tx_q;

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear   (state == S_IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (tx_valid) state_nxt = S_START;
      S_START:  if (bit_done) state_nxt = S_DATA;
      S_DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = pPARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP:   if (bit_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Rotate rather than shift so all eight bits are still present for parity.
  always_comb begin
    shreg_nxt = shreg;
    if (accept)                           shreg_nxt = tx_data;
    else if (state == S_DATA && bit_done) shreg_nxt = {shreg[0], shreg[7:1]};
  end

  always_comb begin
    tx_nxt = 1'b1;
    unique case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[0];
      S_PARITY: tx_nxt = (^shreg_nxt) ^ pPARITY_ODD;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      tx_q  <= tx_nxt;
      if (accept)                           bit_idx <= '0;
      else if (state == S_DATA && bit_done) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule
